// File: rtl/aes_inv_key_sequencer_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the reverse-order
// AES-128 round-key sequencer.
package aes_inv_key_sequencer_pkg;

  localparam int KEY_SIZE   = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int WORD_W     = 32;

  localparam int W0_LSB = 0;
  localparam int W1_LSB = 32;
  localparam int W2_LSB = 64;
  localparam int W3_LSB = 96;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_EXPAND = 2'd1;
  localparam state_t ST_SERVE  = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (round r-1 -> r) or inverse
// (round r -> r-1), sharing a single g-function.
module aes_key_step
  import aes_inv_key_sequencer_pkg::*;
(
  input  logic [KEY_SIZE-1:0] key_i,
  input  logic [3:0]          round_i,
  input  logic                inverse_i,
  output logic [KEY_SIZE-1:0] key_o
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] g_in, g_rot, g_sub, t;

  assign w0 = key_i[W0_LSB +: WORD_W];
  assign w1 = key_i[W1_LSB +: WORD_W];
  assign w2 = key_i[W2_LSB +: WORD_W];
  assign w3 = key_i[W3_LSB +: WORD_W];

  // Inverse direction recovers the previous W3 first and feeds that to g.
  assign g_in  = inverse_i ? (w3 ^ w2) : w3;
  assign g_rot = {g_in[23:0], g_in[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign g_sub[gi*8 +: 8] = sbox(g_rot[gi*8 +: 8]);
    end
  endgenerate

  assign t = g_sub ^ {rcon(round_i), 24'h000000};

  always_comb begin
    key_o = '0;
    if (inverse_i) begin
      key_o[W3_LSB +: WORD_W] = w3 ^ w2;
      key_o[W2_LSB +: WORD_W] = w2 ^ w1;
      key_o[W1_LSB +: WORD_W] = w1 ^ w0;
      key_o[W0_LSB +: WORD_W] = w0 ^ t;
    end else begin
      key_o[W0_LSB +: WORD_W] = w0 ^ t;
      key_o[W1_LSB +: WORD_W] = w1 ^ w0 ^ t;
      key_o[W2_LSB +: WORD_W] = w2 ^ w1 ^ w0 ^ t;
      key_o[W3_LSB +: WORD_W] = w3 ^ w2 ^ w1 ^ w0 ^ t;
    end
  end

endmodule

// File: rtl/aes_inv_key_sequencer.sv
// Expands an AES-128 key forward, then streams round keys 10..0 by undoing
// one schedule step per accepted key; only the round-10 key is retained.
module aes_inv_key_sequencer
  import aes_inv_key_sequencer_pkg::*;
#(
  parameter int KEY_SIZE   = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                key_load,
  input  logic                restart,
  output logic [KEY_SIZE-1:0] out_key,
  output logic [3:0]          out_round,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t              state_q, state_d;
  logic [KEY_SIZE-1:0] cur_q, cur_d;
  logic [KEY_SIZE-1:0] rk_last_q, rk_last_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          round_q, round_d;

  logic [KEY_SIZE-1:0] step_key;
  logic [3:0]          step_round;
  logic                step_inverse;

  assign step_inverse = (state_q == ST_SERVE);
  assign step_round   = (state_q == ST_EXPAND) ? cnt_q : round_q;

  aes_key_step u_step (
    .key_i     (cur_q),
    .round_i   (step_round),
    .inverse_i (step_inverse),
    .key_o     (step_key)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rk_last_d = rk_last_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    if (key_load) begin
      cur_d   = key_in;
      cnt_d   = 4'd1;
      state_d = ST_EXPAND;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          cur_d = step_key;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_ROUND) begin
            rk_last_d = step_key;
            round_d   = LAST_ROUND;
            state_d   = ST_SERVE;
          end
        end
        ST_SERVE: begin
          // restart outranks the handshake; an accepted key in that cycle is dropped.
          if (restart) begin
            cur_d   = rk_last_q;
            round_d = LAST_ROUND;
          end else if (out_ready) begin
            if (round_q != 4'd0) begin
              cur_d   = step_key;
              round_d = round_q - 4'd1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (restart) begin
            cur_d   = rk_last_q;
            round_d = LAST_ROUND;
            state_d = ST_SERVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      rk_last_q <= '0;
      cnt_q     <= 4'd0;
      round_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rk_last_q <= rk_last_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
    end
  end

  assign out_key   = cur_q;
  assign out_round = round_q;
  assign out_valid = (state_q == ST_SERVE);
  assign busy      = (state_q == ST_EXPAND);

endmodule
